// File: rtl/mmu_pkg.sv
// Shared types and defaults for the systolic matrix-unit sequencer.
// BIT_WIDTH / ACC_WIDTH are kept here so that the datapath and the
// sequencer use the same package. The sequencer itself does not depend on them.
package mmu_pkg;

    localparam int MMU_BIT_WIDTH = 8;
    localparam int MMU_ACC_WIDTH = 16;
    localparam int MMU_SIZE      = 16;
    localparam int MMU_MAX_VEC   = 256;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_WT = 3'd1,
        SETTLE  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } mmu_state_e;

    // Latency from the row-0 activation to the registered column-0 result.
    function automatic int mmu_pipe_lat(input int size);
        return size + 1;
    endfunction

endpackage

// File: rtl/mmu_skew_gen.sv
// Per-row activation-valid and per-column result-valid masks.
// Both masks are derived from the COMPUTE cycle counter by comparison.
// Row i is live for c in [i, i+nv).
// Column j is live for c in [PIPE_LAT+j, PIPE_LAT+j+nv).
module mmu_skew_gen #(
    parameter int SIZE     = 16,
    parameter int PIPE_LAT = 17,
    parameter int CW       = 9,
    parameter int VW       = 9
) (
    input  logic [CW-1:0]   c_i,
    input  logic [VW-1:0]   nv_i,
    input  logic            active_i,
    output logic [SIZE-1:0] row_en_o,
    output logic [SIZE-1:0] col_vld_o
);

    // One extra bit so that offset + num_vec can never wrap.
    localparam int EW = CW + 1;

    logic [EW-1:0] c_e;
    logic [EW-1:0] nv_e;

    assign c_e  = EW'(c_i);
    assign nv_e = EW'(nv_i);

    // Window comparators for every row and every column.
    always_comb begin
        row_en_o  = {SIZE{1'b0}};
        col_vld_o = {SIZE{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            row_en_o[i]  = active_i && (c_e >= EW'(i)) &&
                           (c_e < (EW'(i) + nv_e));
            col_vld_o[i] = active_i && (c_e >= EW'(PIPE_LAT + i)) &&
                           (c_e < (EW'(PIPE_LAT + i) + nv_e));
        end
    end

endmodule

// File: rtl/mmu_seq_ctrl.sv
// Sequencer for the weight-stationary systolic matrix unit.
// The sequence is: weight-tile load, one settle cycle, then a skewed
// activation stream with column-valid strobes, and finally a done pulse.
// Every output is registered. Each output is computed from the next state,
// so it is valid in the first cycle of its state.
// Optional feature macro: MMU_CTRL_PERF_EN adds busy-cycle and job counters.
module mmu_seq_ctrl
    import mmu_pkg::*;
#(
    parameter int  SIZE     = MMU_SIZE,
    parameter int  MAX_VEC  = MMU_MAX_VEC,
    parameter int  PIPE_LAT = mmu_pipe_lat(SIZE),
    localparam int VW       = $clog2(MAX_VEC + 1),
    localparam int AW       = $clog2(MAX_VEC),
    localparam int SW       = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            reuse_wt_i,
    input  logic [VW-1:0]   num_vec_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            mmu_control_o,
    output logic            wt_rd_en_o,
    output logic [SW-1:0]   wt_rd_addr_o,
    output logic            act_rd_en_o,
    output logic [AW-1:0]   act_rd_addr_o,
    output logic [SIZE-1:0] act_row_en_o,
    output logic [SIZE-1:0] out_col_vld_o
`ifdef MMU_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_busy_cyc_o,
    output logic [15:0]     perf_jobs_o
`endif
);

    // The shared counter covers the longest COMPUTE phase.
    localparam int            CW        = $clog2(PIPE_LAT + SIZE + MAX_VEC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(SIZE - 1);
    localparam logic [CW-1:0] EXIT_BASE = CW'(PIPE_LAT + SIZE - 2);
    localparam logic [VW-1:0] NV_MAX    = VW'(MAX_VEC);

    mmu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] nv_q, nv_d;
    logic          loaded_q, loaded_d;

    logic            busy_q, done_q, wt_en_q, act_en_q;
    logic [SW-1:0]   wt_addr_q;
    logic [AW-1:0]   act_addr_q;
    logic [SIZE-1:0] row_en_q, col_vld_q;

    logic            busy_d, done_d, wt_en_d, act_en_d, compute_d;
    logic [SW-1:0]   wt_addr_d;
    logic [AW-1:0]   act_addr_d;
    logic [SIZE-1:0] row_en_s, col_vld_s;

    // Next-state, counter, job-parameter and tile-loaded flag logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nv_d     = nv_q;
        loaded_d = loaded_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                // Abort wins over a coincident start.
                if (start_i && !abort_i) begin
                    nv_d    = (num_vec_i > NV_MAX) ? NV_MAX : num_vec_i;
                    state_d = (reuse_wt_i && loaded_q) ? SETTLE : LOAD_WT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WT: begin
                if (abort_i) begin
                    // A partially shifted tile is not reusable.
                    state_d  = IDLE;
                    loaded_d = 1'b0;
                    cnt_d    = {CW{1'b0}};
                end else if (cnt_q == LOAD_LAST) begin
                    state_d  = SETTLE;
                    loaded_d = 1'b1;
                    cnt_d    = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SETTLE: begin
                cnt_d = {CW{1'b0}};
                if (abort_i) begin
                    state_d = IDLE;
                end else if (nv_q == {VW{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q == (EXIT_BASE + CW'(nv_q))) begin
                    state_d = DONE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Output values for the state being entered; they are registered below.
    always_comb begin
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        wt_en_d   = (state_d == LOAD_WT);
        compute_d = (state_d == COMPUTE);
        // Bottom row is shifted in first.
        if (wt_en_d) begin
            wt_addr_d = SW'(SIZE - 1) - cnt_d[SW-1:0];
        end else begin
            wt_addr_d = {SW{1'b0}};
        end
        act_en_d = compute_d && (cnt_d < CW'(nv_d));
        if (act_en_d) begin
            act_addr_d = cnt_d[AW-1:0];
        end else begin
            act_addr_d = {AW{1'b0}};
        end
    end

    mmu_skew_gen #(
        .SIZE     (SIZE),
        .PIPE_LAT (PIPE_LAT),
        .CW       (CW),
        .VW       (VW)
    ) u_skew (
        .c_i       (cnt_d),
        .nv_i      (nv_d),
        .active_i  (compute_d),
        .row_en_o  (row_en_s),
        .col_vld_o (col_vld_s)
    );

    // FSM state, counters and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            nv_q       <= {VW{1'b0}};
            loaded_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wt_en_q    <= 1'b0;
            wt_addr_q  <= {SW{1'b0}};
            act_en_q   <= 1'b0;
            act_addr_q <= {AW{1'b0}};
            row_en_q   <= {SIZE{1'b0}};
            col_vld_q  <= {SIZE{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nv_q       <= nv_d;
            loaded_q   <= loaded_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wt_en_q    <= wt_en_d;
            wt_addr_q  <= wt_addr_d;
            act_en_q   <= act_en_d;
            act_addr_q <= act_addr_d;
            row_en_q   <= row_en_s;
            col_vld_q  <= col_vld_s;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign mmu_control_o = wt_en_q;
    assign wt_rd_en_o    = wt_en_q;
    assign wt_rd_addr_o  = wt_addr_q;
    assign act_rd_en_o   = act_en_q;
    assign act_rd_addr_o = act_addr_q;
    assign act_row_en_o  = row_en_q;
    assign out_col_vld_o = col_vld_q;

`ifdef MMU_CTRL_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_jobs_q;

    // Saturating busy-cycle counter and wrapping job counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_q <= 32'd0;
            perf_jobs_q <= 16'd0;
        end else begin
            if (busy_q && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (done_q) begin
                perf_jobs_q <= perf_jobs_q + 16'd1;
            end
        end
    end

    assign perf_busy_cyc_o = perf_busy_q;
    assign perf_jobs_o     = perf_jobs_q;
`endif

endmodule
